// File: rtl/column_update_engine_if.sv
// column_update_engine_if: handshake and data bundle between the column sweep controller and one column update engine.
interface column_update_engine_if #(
    parameter int I = 20,
    parameter int N = 32
);
    logic                start;
    logic signed [N-1:0] xhat_j;
    logic signed [N-1:0] inv_norm2_j;
    logic signed [N-1:0] lambda;
    logic signed [N-1:0] A_j [0:I-1];
    logic signed [N-1:0] r_in [0:I-1];
    logic signed [N-1:0] max_xj_in;
    logic signed [N-1:0] max_dxj_in;
    logic signed [N-1:0] r_out [0:I-1];
    logic signed [N-1:0] nxt_xhat_j;
    logic signed [N-1:0] max_xj_out;
    logic signed [N-1:0] max_dxj_out;
    logic                busy;
    logic                done;

    modport master (
        output start, xhat_j, inv_norm2_j, lambda, A_j, r_in, max_xj_in, max_dxj_in,
        input  r_out, nxt_xhat_j, max_xj_out, max_dxj_out, busy, done
    );
    modport slave (
        input  start, xhat_j, inv_norm2_j, lambda, A_j, r_in, max_xj_in, max_dxj_in,
        output r_out, nxt_xhat_j, max_xj_out, max_dxj_out, busy, done
    );
endinterface

// File: rtl/column_update_engine.sv
// column_update_engine: one lasso coordinate-descent step for column j (correlate, soft-threshold, residual write-back).
// Optional COLUMN_UPDATE_SKIP_ZERO_EN: when dx==0 the residual write-back collapses into one copy cycle.
module column_update_engine #(
    parameter int I = 20,
    parameter int Q = 15,
    parameter int N = 32
) (
    input logic clk,
    input logic rst,
    column_update_engine_if.slave bus
);
    localparam int IW = I > 1 ? $clog2(I) : 1;
    localparam int AW = 2 * N + $clog2(I);
    localparam int W = AW + 2;
    typedef logic signed [N-1:0] word_t;
    typedef logic signed [W-1:0] wide_t;
    typedef enum logic [2:0] {IDLE, DOT, SCALE, SHRINK, RESID, FIN} state_t;
    localparam word_t MAXV = {1'b0, {(N-1){1'b1}}};
    localparam word_t MINV = {1'b1, {(N-1){1'b0}}};

    function automatic word_t sat(input wide_t v);
        return (v[W-1:N-1] == {(W-N+1){v[W-1]}}) ? v[N-1:0] : (v[W-1] ? MINV : MAXV);
    endfunction

    function automatic wide_t mul(input word_t a, input word_t b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return W'(p >>> Q);
    endfunction

    function automatic wide_t ext(input word_t v);
        return W'(v);
    endfunction

    function automatic word_t abs_sat(input word_t v);
        return v == MINV ? MAXV : (v[N-1] ? -v : v);
    endfunction

    state_t                state;
    logic [IW-1:0]         idx;
    logic signed [AW-1:0]  acc;
    word_t                 xh, inv, lam, mx, mdx, z, thr, dx;
    word_t                 g_c, z_c, thr_c, x_new_c, dx_c, ax_c, adx_c;
    logic signed [2*N-1:0] prod_c;
    logic                  last_c, resid_end_c;

    always_comb begin
        prod_c = bus.A_j[idx] * bus.r_in[idx];
        g_c = sat(W'(acc >>> Q));
        z_c = sat(ext(xh) + mul(g_c, inv));
        thr_c = sat(mul(lam, inv));
        x_new_c = z > thr ? z - thr : (z < -thr ? z + thr : '0);
        dx_c = sat(ext(x_new_c) - ext(xh));
        ax_c = abs_sat(x_new_c);
        adx_c = abs_sat(dx_c);
        last_c = idx == IW'(I - 1);
`ifdef COLUMN_UPDATE_SKIP_ZERO_EN
        resid_end_c = last_c || dx == '0;
`else
        resid_end_c = last_c;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            {xh, inv, lam, mx, mdx, z, thr, dx} <= '0;
            bus.nxt_xhat_j <= '0;
            bus.max_xj_out <= '0;
            bus.max_dxj_out <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            for (int k = 0; k < I; k++) bus.r_out[k] <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= bus.start ? DOT : IDLE;
                    if (bus.start) begin
                        xh <= bus.xhat_j;
                        inv <= bus.inv_norm2_j;
                        lam <= bus.lambda;
                        mx <= bus.max_xj_in;
                        mdx <= bus.max_dxj_in;
                        acc <= '0;
                        idx <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                DOT: begin
                    acc <= acc + AW'(prod_c);
                    idx <= last_c ? '0 : idx + 1'b1;
                    state <= last_c ? SCALE : DOT;
                end
                SCALE: begin
                    z <= z_c;
                    thr <= thr_c;
                    state <= SHRINK;
                end
                SHRINK: begin
                    dx <= dx_c;
                    bus.nxt_xhat_j <= x_new_c;
                    bus.max_xj_out <= ax_c > mx ? ax_c : mx;
                    bus.max_dxj_out <= adx_c > mdx ? adx_c : mdx;
                    state <= RESID;
                end
                RESID: begin
`ifdef COLUMN_UPDATE_SKIP_ZERO_EN
                    if (dx == '0)
                        for (int k = 0; k < I; k++) bus.r_out[k] <= bus.r_in[k];
                    else
                        bus.r_out[idx] <= sat(ext(bus.r_in[idx]) - mul(bus.A_j[idx], dx));
`else
                    bus.r_out[idx] <= sat(ext(bus.r_in[idx]) - mul(bus.A_j[idx], dx));
`endif
                    idx <= idx + 1'b1;
                    if (resid_end_c) begin
                        state <= FIN;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_column_update_engine.sv
// tb_column_update_engine: randomized and directed checks of column_update_engine against a wide-arithmetic model.
module tb_column_update_engine;
    localparam int I = 4;
    localparam int Q = 15;
    localparam int N = 32;
    localparam int LAT_FULL = 2 * I + 3;
`ifdef COLUMN_UPDATE_SKIP_ZERO_EN
    localparam int LAT_ZERO = I + 4;
`else
    localparam int LAT_ZERO = 2 * I + 3;
`endif

    typedef logic signed [127:0] big_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    column_update_engine_if #(.I(I), .N(N)) bus();
    column_update_engine #(.I(I), .Q(Q), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int errs = 0;
    int ecnt = 0;
    int acc_edge = 0;
    int L = LAT_FULL;
    bit active = 0;
    bit armed = 0;
    int ex_x, ex_mx, ex_mdx;
    int ex_r [I];
    int p_x, p_mx, p_mdx, p_L;
    int p_r [I];
    int mk;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic int clampw(input big_t v);
        if (v > big_t'(32'sh7fffffff)) return 32'sh7fffffff;
        if (v < -big_t'(32'sh7fffffff) - 1) return int'(32'h80000000);
        return int'(v[31:0]);
    endfunction

    function automatic big_t mulb(input int a, input int b);
        return (big_t'(a) * big_t'(b)) >>> Q;
    endfunction

    function automatic int abs_s(input int v);
        return v == int'(32'h80000000) ? 32'sh7fffffff : (v < 0 ? -v : v);
    endfunction

    task automatic model(input int xh, input int inv, input int lam, input int mx, input int mdx);
        big_t acc;
        int g, z, thr, xn, dx;
        acc = 0;
        for (int i = 0; i < I; i++) acc += big_t'(bus.A_j[i]) * big_t'(bus.r_in[i]);
        g = clampw(acc >>> Q);
        z = clampw(big_t'(xh) + mulb(g, inv));
        thr = clampw(mulb(lam, inv));
        xn = z > thr ? z - thr : (z < -thr ? z + thr : 0);
        dx = clampw(big_t'(xn) - big_t'(xh));
        p_x = xn;
        p_mx = abs_s(xn) > mx ? abs_s(xn) : mx;
        p_mdx = abs_s(dx) > mdx ? abs_s(dx) : mdx;
        for (int i = 0; i < I; i++) p_r[i] = clampw(big_t'(bus.r_in[i]) - mulb(bus.A_j[i], dx));
        p_L = dx == 0 ? LAT_ZERO : LAT_FULL;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h) at edge %0d", nm, $signed(act), act, $signed(exp), exp, ecnt);
        end
    endtask

    always @(negedge clk) if (armed) begin
        mk = active ? ecnt - acc_edge + 1 : 0;
        chk("busy", 32'(bus.busy), 32'(active && mk >= 1 && mk <= L - 1));
        chk("done", 32'(bus.done), 32'(active && mk == L));
        if (!active || mk >= I + 3) begin
            chk("nxt_xhat_j", bus.nxt_xhat_j, ex_x);
            chk("max_xj_out", bus.max_xj_out, ex_mx);
            chk("max_dxj_out", bus.max_dxj_out, ex_mdx);
        end
        if (!active || mk >= L)
            for (int i = 0; i < I; i++) chk($sformatf("r_out[%0d]", i), bus.r_out[i], ex_r[i]);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_model();
        active = 0;
        ex_x = 0;
        ex_mx = 0;
        ex_mdx = 0;
        for (int i = 0; i < I; i++) ex_r[i] = 0;
    endtask

    task automatic set_vec(input int a, input int r);
        for (int i = 0; i < I; i++) begin
            bus.A_j[i] = a;
            bus.r_in[i] = r;
        end
    endtask

    task automatic go(input int xh, input int inv, input int lam, input int mx, input int mdx);
        bit ok;
        bus.xhat_j = xh;
        bus.inv_norm2_j = inv;
        bus.lambda = lam;
        bus.max_xj_in = mx;
        bus.max_dxj_in = mdx;
        bus.start = 1'b1;
        ok = !active || (ecnt - acc_edge + 1 >= L);
        if (ok) model(xh, inv, lam, mx, mdx);
        step(1);
        bus.start = 1'b0;
        if (ok) begin
            active = 1;
            acc_edge = ecnt;
            L = p_L;
            ex_x = p_x;
            ex_mx = p_mx;
            ex_mdx = p_mdx;
            for (int i = 0; i < I; i++) ex_r[i] = p_r[i];
        end
    endtask

    task automatic wait_done(input int want);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        if (bus.done !== 1'b1) begin
            vectors++;
            errs++;
            $display("FAIL done_timeout: no done within 100 cycles, want latency %0d", want);
        end else chk("latency", ecnt - acc_edge + 1, want);
    endtask

    task automatic basic_lits();
        chk("basic_x", bus.nxt_xhat_j, 49152);
        chk("basic_mx", bus.max_xj_out, 49152);
        chk("basic_mdx", bus.max_dxj_out, 49152);
        for (int i = 0; i < I; i++) chk("basic_r", bus.r_out[i], 8192);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.xhat_j = 0;
        bus.inv_norm2_j = 0;
        bus.lambda = 0;
        bus.max_xj_in = 0;
        bus.max_dxj_in = 0;
        set_vec(0, 0);
        step(2);
        rst = 1'b0;
        clear_model();
        armed = 1;
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_x", bus.nxt_xhat_j, 0);

        set_vec(16384, 32768);
        go(0, 32768, 16384, 0, 0);
        wait_done(11);
        basic_lits();

        go(0, 32768, 131072, 0, 0);
        wait_done(LAT_ZERO);
        chk("thr_x", bus.nxt_xhat_j, 0);
        chk("thr_mx", bus.max_xj_out, 0);
        chk("thr_mdx", bus.max_dxj_out, 0);
        for (int i = 0; i < I; i++) chk("thr_r", bus.r_out[i], 32768);

        step(3);
        set_vec(16384, -32768);
        go(0, 32768, 16384, 0, 0);
        wait_done(11);
        chk("neg_x", bus.nxt_xhat_j, -49152);
        chk("neg_mx", bus.max_xj_out, 49152);
        for (int i = 0; i < I; i++) chk("neg_r", bus.r_out[i], -8192);

        step(1);
        set_vec(16384, 32768);
        go(32'sh7fffffff, 32768, 0, 100, 777);
        wait_done(LAT_ZERO);
        chk("sat_x", bus.nxt_xhat_j, 32'h7fffffff);
        chk("sat_mx", bus.max_xj_out, 32'h7fffffff);
        chk("sat_mdx", bus.max_dxj_out, 777);

        step(2);
        go(0, 32768, 16384, 0, 0);
        step(2);
        go(12345, 1, 1, 1, 1);
        wait_done(11);
        basic_lits();

        step(2);
        go(0, 32768, 16384, 0, 0);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        clear_model();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_x", bus.nxt_xhat_j, 0);
        chk("rst_r0", bus.r_out[0], 0);
        step(3);
        go(0, 32768, 16384, 0, 0);
        wait_done(11);
        basic_lits();

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) != 0) step($urandom_range(1, 3));
            for (int i = 0; i < I; i++) begin
                bus.A_j[i] = $urandom_range(0, 7) == 0 ? int'($urandom) : int'($urandom_range(0, 131072)) - 65536;
                bus.r_in[i] = $urandom_range(0, 7) == 0 ? int'($urandom) : int'($urandom_range(0, 131072)) - 65536;
            end
            go(int'($urandom_range(0, 524288)) - 262144,
               int'($urandom_range(1, 131072)),
               $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 200000)),
               int'($urandom_range(0, 262144)),
               int'($urandom_range(0, 262144)));
            wait_done(L);
        end

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/column_update_engine.md
# column_update_engine

Computes one coordinate-descent step for a single column j of the lasso solver, in signed fixed point. The column sweep controller starts it once per column; it holds the result until the next start. The block:
- computes the correlation between column A_j and residual r;
- updates xhat_j by soft-thresholding;
- writes back the new residual;
- tracks the running max |x| and max |dx| across the sweep.

## Interface
Parameters:
- I, 20, rows of A (length of column and residual)
- Q, 15, fractional bits of all fixed-point values
- N, 32, word width (two's complement)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request pulse; ignored unless idle
- xhat_j  input  N  current coefficient of column j
- inv_norm2_j  input  N  precomputed 1/||A_j||², Q-format, positive
- lambda  input  N  regularisation weight, non-negative
- A_j  input  N×[0:I-1]  column j of A
- r_in  input  N×[0:I-1]  residual before this step
- max_xj_in, max_dxj_in  input  N  running maxima from the previous column
- r_out  output  N×[0:I-1]  updated residual, registered
- nxt_xhat_j  output  N  new coefficient
- max_xj_out, max_dxj_out  output  N  updated running maxima
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when all outputs are valid

## Operation
- Fixed-point multiply is mul(a,b) = (a·b full 2N) >>> Q, floor rounding.
- Every N-bit result saturates to [−2^(N−1), 2^(N−1)−1].
- |x| of the most negative value saturates to 2^(N−1)−1.
- On an accepted start, latch into internal registers: xhat_j, inv_norm2_j, lambda, max_xj_in, max_dxj_in. A_j and r_in must stay stable until done.
- States are IDLE → DOT → SCALE → SHRINK → RESID → FIN → IDLE.
- IDLE: busy=0. start=1 clears the accumulator and index, then goes to DOT.
- DOT: one element per cycle, acc += A_j[i]·r_in[i]. acc is 2N+⌈log2 I⌉ bits, with no intermediate rounding. Lasts I cycles.
- SCALE: g = sat(acc >>> Q). z = sat(xhat_j + mul(g, inv_norm2_j)). thr = mul(lambda, inv_norm2_j).
- SHRINK:
  - x_new is z−thr if z>thr, z+thr if z<−thr, otherwise 0.
  - dx = sat(x_new − xhat_j).
  - nxt_xhat_j ← x_new.
  - max_xj_out ← max(max_xj, |x_new|).
  - max_dxj_out ← max(max_dxj, |dx|).
- RESID: one element per cycle, r_out[i] ← sat(r_in[i] − mul(A_j[i], dx)). Lasts I cycles.
- FIN: done=1 for one cycle, busy=0, return to IDLE. Outputs hold until the next accepted start; they are not cleared by start.
- A start while busy is ignored and has no side effects.
- Reset, including mid-operation, forces the following regardless of state, and any in-flight step is discarded:
  - state ← IDLE;
  - all outputs ← 0 (r_out all zero; done=0, busy=0).

## Timing
- Let start be sampled at edge 0.
- DOT occupies cycles 1..I. SCALE is cycle I+1. SHRINK is cycle I+2. RESID occupies I+3..2I+2. done is high in cycle 2I+3.
- Total latency from start to done is 2I+3 cycles: 43 at I=20, 11 at I=4.
- busy is high in cycles 1..2I+2.
- A new start is accepted in the done cycle or any later cycle; back-to-back throughput is one step per 2I+3 cycles.
- nxt_xhat_j and both maxima are valid from cycle I+3. r_out is fully valid only when done=1.

## Configuration
- Macro `COLUMN_UPDATE_SKIP_ZERO_EN`.
- When defined and dx==0 after SHRINK:
  - RESID is replaced by a single cycle that copies r_out ← r_in for all i;
  - done arrives in cycle I+4;
  - dx≠0 behaves as below.
- When undefined: RESID always runs I cycles and latency is always 2I+3.

## Test plan
All scenarios use I=4, Q=15, N=32, so 1.0 = 32768.
- Basic step:
  - Stimulus: A_j all 16384, r_in all 32768, inv_norm2=32768, xhat=0, lambda=16384, maxima 0.
  - Required: nxt_xhat_j=49152, every r_out=8192, max_xj_out=49152, max_dxj_out=49152, done at cycle 11.
- Thresholded to zero:
  - Stimulus: same as basic step but lambda=131072.
  - Required: nxt_xhat_j=0, r_out=r_in, maxima unchanged. done at cycle 11, or cycle 8 with `COLUMN_UPDATE_SKIP_ZERO_EN`.
- Negative branch:
  - Stimulus: r_in all −32768, otherwise as basic step.
  - Required: nxt_xhat_j=−49152, max_xj_out=49152, every r_out=−8192.
- Saturation:
  - Stimulus: xhat=0x7FFFFFFF, lambda=0, g>0.
  - Required: nxt_xhat_j=0x7FFFFFFF, dx=0. max_dxj_out keeps its input value.
- Protocol:
  - Stimulus: second start pulse at cycle 3.
  - Required: it is ignored, done at cycle 11 exactly once.
  - Stimulus: rst at cycle 6.
  - Required: all outputs 0, busy=0, no done. A fresh start then completes in 11 cycles with basic-step results.
